// File: rtl/poly_modq_reduce_stream.sv
// Streaming mod-Q reducer: takes a raw 13-bit adder sum and returns a canonical coefficient in [0,Q).
// Define MODQ_REDUCE_RANGE_CHECK_EN to build the sticky err_range flag for in_sum >= 2*Q.
module poly_modq_reduce_stream #(
  parameter int DATA_WID = 12,
  parameter int Q        = 3329,
  parameter int N_COEFF  = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_WID:0]   in_sum,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_WID-1:0] out_coeff,
  output logic                out_last,
  output logic                poly_done,
  output logic                err_range
);

  localparam int IDX_W = (N_COEFF > 1) ? $clog2(N_COEFF) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_COEFF - 1);
  localparam logic [DATA_WID+1:0] Q_EXT    = (DATA_WID + 2)'(Q);

  logic                en;
  logic                accept;
  logic                s1_valid;
  logic                s1_last;
  logic [DATA_WID:0]   s1_sum;
  logic [DATA_WID+1:0] diff;
  logic [DATA_WID-1:0] reduced;
  logic [IDX_W-1:0]    idx_in;
  logic                unused_bits;

  // The whole pipe advances together; it only freezes when the output beat is stuck.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  // One conditional subtraction: a negative diff means the sum was already below Q.
  assign diff        = {1'b0, s1_sum} - Q_EXT;
  assign reduced     = diff[DATA_WID+1] ? s1_sum[DATA_WID-1:0] : diff[DATA_WID-1:0];
  assign unused_bits = &{1'b0, diff[DATA_WID], s1_sum[DATA_WID]};

  assign poly_done = out_valid && out_ready && out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_in <= '0;
    end else if (accept) begin
      idx_in <= (idx_in == LAST_IDX) ? '0 : idx_in + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_last  <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_sum   <= in_sum;
      s1_last  <= in_valid && (idx_in == LAST_IDX);
    end
  end

  // Output register; coefficient only reloads on real data so bubbles leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_coeff <= '0;
      out_last  <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid;
      out_last  <= s1_valid && s1_last;
      if (s1_valid) begin
        out_coeff <= reduced;
      end
    end
  end

`ifdef MODQ_REDUCE_RANGE_CHECK_EN
  localparam logic [DATA_WID:0] TWO_Q = (DATA_WID + 1)'(2 * Q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_range <= 1'b0;
    end else if (accept && (in_sum >= TWO_Q)) begin
      err_range <= 1'b1;
    end
  end
`else
  assign err_range = 1'b0;
`endif

endmodule

// File: tb/tb_poly_modq_reduce_stream.sv
// Bench for poly_modq_reduce_stream: directed reduction table, reset, full frames, backpressure,
// range error and bubble sequences, with a scoreboard watching every output transfer.
module tb_poly_modq_reduce_stream;

  typedef struct packed {
    logic [12:0] sum;
    logic [11:0] coeff;
  } vec_t;

  typedef struct packed {
    logic [11:0] coeff;
    logic        last;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_sum;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_coeff;
  logic        out_last;
  logic        poly_done;
  logic        err_range;

  int   tests;
  int   failures;
  int   pd_cnt;
  int   out_cnt;
  logic mon_en;
  logic rand_mode;
  logic force_ready;
  logic [7:0]  model_idx;
  logic        held;
  logic [11:0] held_coeff;
  logic        held_last;
  exp_t        exp_q[$];
  vec_t        vecs[11];
  logic        exp_err;

  poly_modq_reduce_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coeff (out_coeff),
    .out_last  (out_last),
    .poly_done (poly_done),
    .err_range (err_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got %0d failures so far, required completion", failures);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] model_reduce(input logic [12:0] s);
    int d;
    d = int'(s) - 3329;
    if (d < 0) return s[11:0];
    return d[11:0];
  endfunction

  // Single isolated beat with the consumer always ready.
  task automatic applyStimulus(input logic [12:0] s);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_sum   = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Streaming beat: hold it until accepted; returns just after the accepting edge.
  task automatic sendBeat(input logic [12:0] s);
    int cnt;
    cnt      = 0;
    in_valid = 1'b1;
    in_sum   = s;
    @(negedge clk);
    while (!in_ready && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    if (!in_ready) begin
      tests++;
      failures++;
      $display("[TB] FAIL send_timeout: in_ready got 0, expected 1 within 1000 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic waitDrain();
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("drain_pending", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = rand_mode ? 1'($urandom_range(0, 1)) : force_ready;
    end
  end

  // Scoreboard: sample away from the rising edge; pushes accepted inputs, pops output transfers.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rst_n) begin
      if (held) begin
        checkOutput("hold_valid", out_valid, 1);
        checkOutput("hold_coeff", out_coeff, held_coeff);
        checkOutput("hold_last", out_last, held_last);
      end
      checkOutput("in_ready_rule", in_ready, 32'(!(out_valid && !out_ready)));
      if (poly_done) pd_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          failures++;
          $display("[TB] FAIL extra_output: got coeff %0d, expected no beat", out_coeff);
        end else begin
          e = exp_q.pop_front();
          out_cnt++;
          checkOutput("sb_coeff", out_coeff, e.coeff);
          checkOutput("sb_last", out_last, e.last);
          checkOutput("sb_poly_done", poly_done, e.last);
        end
      end else begin
        checkOutput("poly_done_idle", poly_done, 0);
      end
      held       = out_valid && !out_ready;
      held_coeff = out_coeff;
      held_last  = out_last;
      if (in_valid && in_ready) begin
        exp_q.push_back({model_reduce(in_sum), model_idx == 8'd255});
        model_idx = (model_idx == 8'd255) ? 8'd0 : model_idx + 8'd1;
      end
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    logic [5:0] pat_in;
    logic [5:0] pat_out;
    logic [5:0] obs;
    int base;

    vecs[0]  = '{sum: 13'd0,    coeff: 12'd0};
    vecs[1]  = '{sum: 13'd3328, coeff: 12'd3328};
    vecs[2]  = '{sum: 13'd3329, coeff: 12'd0};
    vecs[3]  = '{sum: 13'd3330, coeff: 12'd1};
    vecs[4]  = '{sum: 13'd6656, coeff: 12'd3327};
    vecs[5]  = '{sum: 13'd6657, coeff: 12'd3328};
    vecs[6]  = '{sum: 13'd1,    coeff: 12'd1};
    vecs[7]  = '{sum: 13'd2000, coeff: 12'd2000};
    vecs[8]  = '{sum: 13'd4000, coeff: 12'd671};
    vecs[9]  = '{sum: 13'd5000, coeff: 12'd1671};
    vecs[10] = '{sum: 13'd6658, coeff: 12'd3329};

`ifdef MODQ_REDUCE_RANGE_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif

    tests = 0; failures = 0; pd_cnt = 0; out_cnt = 0;
    mon_en = 1'b0; rand_mode = 1'b0; force_ready = 1'b1;
    model_idx = 8'd0; held = 1'b0; held_coeff = '0; held_last = 1'b0;
    in_valid = 1'b0; in_sum = '0; rst_n = 1'b0;

    #2;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_coeff", out_coeff, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_poly_done", poly_done, 0);
    checkOutput("rst_err_range", err_range, 0);
    #20 rst_n = 1'b1;
    mon_en = 1'b1;

    // Reduction corners: one isolated beat each, output due two cycles after presentation.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].sum);
      @(negedge clk);
      checkOutput("t2_early_valid", out_valid, 0);
      @(negedge clk);
      checkOutput("t2_valid", out_valid, 1);
      checkOutput("t2_coeff", out_coeff, vecs[i].coeff);
      checkOutput("t2_last", out_last, 0);
    end
    checkOutput("t2_err_after_6658", err_range, exp_err);

    // Mid-stream reset with a stalled, full pipe.
    force_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    sendBeat(13'd100);
    sendBeat(13'd200);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("t1_stall_valid", out_valid, 1);
    checkOutput("t1_stall_ready", in_ready, 0);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    checkOutput("t1_in_ready", in_ready, 1);
    checkOutput("t1_out_valid", out_valid, 0);
    checkOutput("t1_out_coeff", out_coeff, 0);
    checkOutput("t1_out_last", out_last, 0);
    checkOutput("t1_poly_done", poly_done, 0);
    checkOutput("t1_err_range", err_range, 0);
    force_ready = 1'b1;
    @(posedge clk); @(posedge clk); #3;
    checkOutput("t1_hold_in_reset", out_valid, 0);
    rst_n = 1'b1;
    exp_q.delete();
    model_idx = 8'd0;
    pd_cnt    = 0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Full polynomial, back to back.
    for (int i = 0; i < 256; i++) sendBeat(13'(i));
    in_valid = 1'b0;
    waitDrain();
    checkOutput("t3_poly_done_count", pd_cnt, 1);

    // Random backpressure over four frames.
    rand_mode = 1'b1;
    base = out_cnt;
    for (int i = 0; i < 1024; i++) sendBeat(13'($urandom_range(0, 6657)));
    in_valid = 1'b0;
    waitDrain();
    rand_mode = 1'b0;
    checkOutput("t4_beats_out", out_cnt - base, 1024);
    checkOutput("t4_poly_done_count", pd_cnt, 5);

    // Range error: 6657 is the largest legal sum, 6658 the first illegal one.
    sendBeat(13'd6657);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("t5_err_at_6657", err_range, 0);
    @(posedge clk); #1;
    sendBeat(13'd6658);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("t5_err_at_6658", err_range, exp_err);
    @(posedge clk); #1;
    sendBeat(13'd5);
    in_valid = 1'b0;
    waitDrain();
    checkOutput("t5_err_sticky", err_range, exp_err);

    // Bubbles: the valid pattern reappears two cycles later.
    repeat (3) begin @(posedge clk); #1; end
    pat_in  = 6'b001001;
    pat_out = 6'b100100;
    obs     = '0;
    for (int k = 0; k < 6; k++) begin
      in_valid = pat_in[k];
      in_sum   = 13'(100 + k);
      @(negedge clk);
      obs[k] = out_valid;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) checkOutput("t6_valid_pattern", obs[k], pat_out[k]);
    waitDrain();

    // Finish the frame: only valid beats count, so the last flag lands on the 256th beat.
    for (int i = 0; i < 251; i++) sendBeat(13'(3000 + i));
    in_valid = 1'b0;
    waitDrain();
    checkOutput("t6_poly_done_count", pd_cnt, 6);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
